// File: rtl/digit_scan_mux.sv
// Four-digit multiplexed display scanner: shadow-buffered digits, prescaled slot
// rotation, leading-zero blanking and sticky invalid-digit flag.
module digit_scan_mux #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] digits_in,
    input  logic        load,
    input  logic        blank_lead,
    output logic [4:0]  digital,
    output logic [3:0]  anode_n,
    output logic        scan_tick,
    output logic        err
);

    localparam int unsigned     CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] presc;
    logic [1:0]    idx;
    logic [19:0]   sh_digits;
    logic          sh_blank;
    logic          show_q;

    logic [1:0]    nidx;
    logic [4:0]    nd;
    logic          z1, z2, z3;
    logic          nd_bad, nd_blank, nd_show;

    // Everything below looks at the slot about to be entered, using the shadow
    // as it stands before the boundary edge.
    always_comb begin
        nidx = idx + 2'd1;
        nd   = '0;
        case (nidx)
            2'd0: nd = sh_digits[4:0];
            2'd1: nd = sh_digits[9:5];
            2'd2: nd = sh_digits[14:10];
            2'd3: nd = sh_digits[19:15];
            default: nd = '0;
        endcase
        z3 = (sh_digits[19:15] == 5'd0);
        z2 = z3 && (sh_digits[14:10] == 5'd0);
        z1 = z2 && (sh_digits[9:5] == 5'd0);
        nd_blank = 1'b0;
        case (nidx)
            2'd1: nd_blank = sh_blank && z1;
            2'd2: nd_blank = sh_blank && z2;
            2'd3: nd_blank = sh_blank && z3;
            default: nd_blank = 1'b0;
        endcase
        nd_bad  = (nd > 5'd9);
        nd_show = !nd_bad && !nd_blank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            scan_tick <= 1'b0;
        end else begin
            presc     <= (presc == LAST) ? '0 : presc + 1'b1;
            scan_tick <= (presc == LAST);
        end
    end

    // Anodes stay dark for the first cycle of each slot so the downstream
    // decoder register has caught up with the new digit value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= 2'd3;
            sh_digits <= '0;
            sh_blank  <= 1'b0;
            digital   <= '0;
            anode_n   <= '1;
            show_q    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (load) begin
                sh_digits <= digits_in;
                sh_blank  <= blank_lead;
            end
            err <= (err && !load) || (scan_tick && nd_bad);
            if (scan_tick) begin
                idx     <= nidx;
                digital <= nd_show ? nd : '0;
                show_q  <= nd_show;
                anode_n <= '1;
            end else begin
                anode_n <= show_q ? ~(4'b0001 << idx) : '1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed + random bench for digit_scan_mux with REFRESH_DIV=4; expected slot
// contents are queued when loads are driven and checked as each slot is scanned.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] digits_in;
    logic        load;
    logic        blank_lead;
    logic [4:0]  digital;
    logic [3:0]  anode_n;
    logic        scan_tick;
    logic        err;

    digit_scan_mux #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .blank_lead (blank_lead),
        .digital    (digital),
        .anode_n    (anode_n),
        .scan_tick  (scan_tick),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] d;
        logic [3:0] an;
        logic       e;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] mon_idx   = 2'd3;
    int         slot_cyc  = 0;
    logic       prev_tick = 1'b0;
    int         gap       = 0;
    logic       have_rec  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] d, input logic [3:0] an, input logic e);
        q.push_back('{d, an, e});
    endtask

    task automatic do_load(input logic [19:0] d, input logic b);
        digits_in  = d;
        blank_lead = b;
        load       = 1'b1;
        @(negedge clk); #2;
        load       = 1'b0;
    endtask

    task automatic wait_slot(input logic [1:0] idx, input int cyc);
        logic ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk); #2;
            if (mon_idx == idx && slot_cyc == cyc) ok = 1'b1;
        end
        chk("wait_slot", ok, 1);
    endtask

    task automatic wait_drain();
        logic ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (q.size() == 0 && !have_rec) ok = 1'b1;
            else begin @(negedge clk); #2; end
        end
        chk("drain", ok, 1);
    endtask

    // Slot tracker and checker: one negedge sample per cycle.
    always @(negedge clk) begin
        if (reset) begin
            mon_idx   = 2'd3;
            slot_cyc  = 0;
            prev_tick = 1'b0;
            gap       = 0;
            have_rec  = 1'b0;
        end else begin
            if (prev_tick) begin
                mon_idx  = mon_idx + 2'd1;
                slot_cyc = 0;
                if (q.size() > 0) begin
                    cur      = q.pop_front();
                    have_rec = 1'b1;
                end
            end else begin
                slot_cyc++;
            end
            prev_tick = scan_tick;
            gap++;
            if (scan_tick) begin
                chk("tick_gap", gap, 4);
                gap = 0;
            end
            chk("anode_onehot", ($countones(~anode_n) <= 1), 1);
            if (slot_cyc == 0) chk("anode_first", anode_n, 4'hF);
            if (have_rec) begin
                chk("digital", digital, cur.d);
                if (slot_cyc != 0) chk("anode", anode_n, cur.an);
                if (slot_cyc <= 1) chk("err", err, cur.e);
                if (slot_cyc >= 3) have_rec = 1'b0;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        blank_lead = 1'b0;
        #3;
        chk("rst_digital", digital, 0);
        chk("rst_anode", anode_n, 4'hF);
        chk("rst_tick", scan_tick, 0);
        chk("rst_err", err, 0);
        @(negedge clk); #2;
        reset = 1'b0;

        // Basic rotation {4,3,2,1}
        push(5'd1, 4'b1110, 0); push(5'd2, 4'b1101, 0); push(5'd3, 4'b1011, 0);
        push(5'd4, 4'b0111, 0); push(5'd1, 4'b1110, 0);
        do_load({5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        wait_drain();

        // Load coincident with the boundary into slot 0
        wait_slot(2'd3, 3);
        push(5'd1, 4'b1110, 0); push(5'd7, 4'b1101, 0);
        push(5'd8, 4'b1011, 0); push(5'd9, 4'b0111, 0);
        do_load({5'd9, 5'd8, 5'd7, 5'd6}, 1'b0);
        wait_drain();

        // Leading-zero blanking
        wait_slot(2'd3, 1);
        push(5'd0, 4'b1110, 0); push(5'd5, 4'b1101, 0);
        push(5'd0, 4'b1111, 0); push(5'd0, 4'b1111, 0);
        do_load({5'd0, 5'd0, 5'd5, 5'd0}, 1'b1);
        wait_drain();
        wait_slot(2'd3, 1);
        push(5'd0, 4'b1110, 0); push(5'd0, 4'b1111, 0);
        push(5'd0, 4'b1111, 0); push(5'd0, 4'b1111, 0);
        do_load(20'd0, 1'b1);
        wait_drain();

        // Invalid digit 2 = 12, sticky err, cleared by a valid load
        wait_slot(2'd3, 1);
        push(5'd0, 4'b1110, 0); push(5'd0, 4'b1101, 0); push(5'd0, 4'b1111, 1);
        push(5'd0, 4'b0111, 1); push(5'd0, 4'b1110, 1);
        do_load({5'd0, 5'd12, 5'd0, 5'd0}, 1'b0);
        wait_drain();
        wait_slot(2'd1, 1);
        chk("err_held", err, 1);
        push(5'd2, 4'b1011, 0); push(5'd1, 4'b0111, 0);
        do_load({5'd1, 5'd2, 5'd3, 5'd4}, 1'b0);
        chk("err_clear", err, 0);
        wait_drain();

        // Invalid scanned on the same edge as a load: err must end up set
        wait_slot(2'd1, 1);
        push(5'd2, 4'b1011, 0); push(5'd3, 4'b0111, 0);
        do_load({5'd3, 5'd2, 5'd1, 5'd15}, 1'b0);
        wait_slot(2'd3, 3);
        push(5'd0, 4'b1111, 1);
        do_load({5'd3, 5'd2, 5'd1, 5'd15}, 1'b0);
        wait_drain();

        // Asynchronous reset mid slot 2
        wait_slot(2'd2, 2);
        chk("pre_rst_digital", digital, 2);
        chk("pre_rst_anode", anode_n, 4'b1011);
        #1 reset = 1'b1;
        #1;
        chk("arst_digital", digital, 0);
        chk("arst_anode", anode_n, 4'hF);
        chk("arst_tick", scan_tick, 0);
        chk("arst_err", err, 0);
        @(negedge clk); #2;
        reset = 1'b0;
        push(5'd0, 4'b1110, 0);
        wait_drain();

        // Random loads; the monitor enforces the anode invariants
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #2;
            load       = ($urandom_range(0, 7) == 0);
            digits_in  = 20'($urandom);
            blank_lead = 1'($urandom_range(0, 1));
        end
        load = 1'b0;
        @(negedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
